// File: rtl/wt_dcache_mem_responder.sv
// Memory-side responder for the write-through dcache: queues line loads and byte-enabled
// stores, services them one at a time from a 64-bit RAM and returns in-order tagged acks.
module wt_dcache_mem_responder #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DepthWords   = 1024,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned ExtraLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_type_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  input  logic [63:0]          req_wdata_i,
  input  logic [7:0]           req_be_i,
  output logic                 rtrn_valid_o,
  output logic                 rtrn_type_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic [127:0]         rtrn_data_o,
  output logic                 busy_o
);

  localparam int unsigned WIdxW = $clog2(DepthWords);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned LatW  = (ExtraLatency > 0) ? $clog2(ExtraLatency + 1) : 1;
  localparam logic [LatW-1:0] LastCnt = (ExtraLatency > 0) ? LatW'(ExtraLatency - 1) : '0;

  typedef struct packed {
    logic                typ;
    logic [WIdxW-1:0]    word;
    logic [TidWidth-1:0] tid;
    logic [63:0]         wdata;
    logic [7:0]          be;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_LD0, S_LD1, S_ST, S_WAIT, S_RESP} state_e;

  state_e            r_state, w_next;
  req_t              r_fifo [FifoDepth];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [PtrW:0]     r_cnt;
  req_t              r_cur;
  logic [127:0]      r_line;
  logic [LatW-1:0]   r_wcnt;
  logic [63:0]       r_mem [DepthWords];

  req_t              w_req, w_head;
  logic              w_full, w_empty, w_push, w_pop, w_resp;
  logic [WIdxW-1:0]  w_base_lo, w_base_hi;
  logic              w_unused;

  // Only the word-index bits of the byte address matter; the rest wrap away.
  assign w_unused = ^{req_addr_i[AddrWidth-1:WIdxW+3], req_addr_i[2:0]};

  always_comb begin
    w_req       = '0;
    w_req.typ   = req_type_i;
    w_req.word  = req_addr_i[WIdxW+2:3];
    w_req.tid   = req_tid_i;
    w_req.wdata = req_wdata_i;
    w_req.be    = req_be_i;
  end

  assign w_full      = (r_cnt == (PtrW+1)'(FifoDepth));
  assign w_empty     = (r_cnt == '0);
  assign req_ready_o = !rst_i && !w_full;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_head      = r_fifo[r_rptr];

  // Request queue storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_req;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_head.typ ? S_ST : S_LD0;
        end
      end
      S_LD0:  w_next = S_LD1;
      S_LD1:  w_next = (ExtraLatency == 0) ? S_RESP : S_WAIT;
      S_ST:   w_next = (ExtraLatency == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_wcnt == LastCnt) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;
      else                   r_wcnt <= '0;
    end
  end

  assign w_base_lo = {r_cur.word[WIdxW-1:1], 1'b0};
  assign w_base_hi = {r_cur.word[WIdxW-1:1], 1'b1};

  // Working register and RAM; a store commits in ST, before any later pop.
  always_ff @(posedge clk_i) begin
    if (w_pop) r_cur <= w_head;
    if (r_state == S_LD0) r_line[63:0]   <= r_mem[w_base_lo];
    if (r_state == S_LD1) r_line[127:64] <= r_mem[w_base_hi];
    if (!rst_i && r_state == S_ST) begin
      for (int i = 0; i < 8; i++) begin
        if (r_cur.be[i]) r_mem[r_cur.word][8*i +: 8] <= r_cur.wdata[8*i +: 8];
      end
    end
  end

  assign w_resp       = (r_state == S_RESP);
  assign rtrn_valid_o = w_resp;
  assign rtrn_type_o  = w_resp && r_cur.typ;
  assign rtrn_tid_o   = w_resp ? r_cur.tid : '0;
  assign rtrn_data_o  = (w_resp && !r_cur.typ) ? r_line : '0;
  assign busy_o       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Randomized bench for wt_dcache_mem_responder: a transaction-level model predicts data,
// response cycle, queue-full backpressure and busy; a second instance covers zero extra latency.
module tb_wt_dcache_mem_responder;

  localparam int EL = 2;
  localparam int FD = 4;
  localparam int DW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: default parameters
  logic         a_vld = 1'b0, a_typ = 1'b0;
  logic [63:0]  a_addr = '0, a_wd = '0;
  logic [1:0]   a_tid = '0;
  logic [7:0]   a_be = '0;
  logic         a_rdy, a_rv, a_rtyp, a_busy;
  logic [1:0]   a_rtid;
  logic [127:0] a_rdata;

  // instance B: no extra latency, small memory
  logic         b_vld = 1'b0, b_typ = 1'b0;
  logic [63:0]  b_addr = '0, b_wd = '0;
  logic [1:0]   b_tid = '0;
  logic [7:0]   b_be = '0;
  logic         b_rdy, b_rv, b_rtyp, b_busy;
  logic [1:0]   b_rtid;
  logic [127:0] b_rdata;

  wt_dcache_mem_responder #(.AddrWidth(64), .DepthWords(DW), .TidWidth(2), .FifoDepth(FD), .ExtraLatency(EL)) u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(a_vld), .req_ready_o(a_rdy), .req_type_i(a_typ),
    .req_addr_i(a_addr), .req_tid_i(a_tid), .req_wdata_i(a_wd), .req_be_i(a_be),
    .rtrn_valid_o(a_rv), .rtrn_type_o(a_rtyp), .rtrn_tid_o(a_rtid), .rtrn_data_o(a_rdata), .busy_o(a_busy));

  wt_dcache_mem_responder #(.AddrWidth(64), .DepthWords(64), .TidWidth(2), .FifoDepth(2), .ExtraLatency(0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_vld), .req_ready_o(b_rdy), .req_type_i(b_typ),
    .req_addr_i(b_addr), .req_tid_i(b_tid), .req_wdata_i(b_wd), .req_be_i(b_be),
    .rtrn_valid_o(b_rv), .rtrn_type_o(b_rtyp), .rtrn_tid_o(b_rtid), .rtrn_data_o(b_rdata), .busy_o(b_busy));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: requests are served strictly in order, so applying each one to the
  // memory image at accept time gives the data it will return. Timing is plain arithmetic:
  // service begins at max(accept edge, previous response edge + 1).
  typedef struct {
    logic         typ;
    logic [1:0]   tid;
    logic [127:0] data;
    int           r;
  } exp_t;

  exp_t        expq[$];
  int          popq[$];
  int          r_last = -1000;
  int          last_p = 0;
  logic [63:0] mm [DW];
  bit          mon = 1'b0;
  exp_t        me;

  task automatic send(input logic typ, input logic [63:0] addr, input logic [1:0] tid,
                      input logic [63:0] wd, input logic [7:0] be);
    int   n, p, w, b;
    bit   ok;
    exp_t e;
    a_vld = 1'b1; a_typ = typ; a_addr = addr; a_tid = tid; a_wd = wd; a_be = be;
    ok = 1'b0; n = 0;
    while (!ok && n < 100) begin
      @(negedge clk); ok = a_rdy;
      @(posedge clk); #1; n++;
    end
    if (!ok) begin
      chk("accept_timeout", 1'b0, 1'b1);
      return;
    end
    p = (cyc > r_last + 1) ? cyc : r_last + 1;
    last_p = p;
    e.r = p + (typ ? 2 + EL : 3 + EL);
    r_last = e.r;
    popq.push_back(p + 1);
    w = int'((addr >> 3) & 64'(DW - 1));
    if (typ) begin
      for (int i = 0; i < 8; i++) if (be[i]) mm[w][8*i +: 8] = wd[8*i +: 8];
      e.data = '0;
    end else begin
      b = w & ~1;
      e.data = {mm[b+1], mm[b]};
    end
    e.typ = typ; e.tid = tid;
    expq.push_back(e);
  endtask

  task automatic gap(input int n);
    a_vld = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    a_vld = 1'b0;
    while (expq.size() > 0 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("drain", expq.size(), 0);
    gap(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete(); popq.delete(); r_last = -1000;
  endtask

  always @(negedge clk) begin
    if (mon) begin
      if (rst) begin
        chk("rst_ready", a_rdy, 1'b0);
        chk("rst_pulse", a_rv, 1'b0);
      end else begin
        while (popq.size() > 0 && popq[0] <= cyc) void'(popq.pop_front());
        chk("ready", a_rdy, popq.size() < FD);
        chk("busy", a_busy, (popq.size() > 0) || (cyc <= r_last));
        if (a_rv) begin
          if (expq.size() == 0) chk("spurious_pulse", a_rv, 1'b0);
          else begin
            me = expq.pop_front();
            chk("rtrn_type", a_rtyp, me.typ);
            chk("rtrn_tid", a_rtid, me.tid);
            chk("rtrn_data", a_rdata, me.data);
            chk("rtrn_cycle", cyc, me.r);
          end
        end else if (expq.size() > 0 && expq[0].r < cyc) begin
          chk("missing_pulse", cyc, expq[0].r);
          void'(expq.pop_front());
        end
      end
    end
  end

  // Isolated request on B; latency is counted in clock edges from the accept edge.
  task automatic b_txn(input string tag, input logic typ, input logic [63:0] addr, input logic [1:0] tid,
                       input logic [63:0] wd, input logic [7:0] be, input logic [127:0] exp_d, input int exp_lat);
    int e0, n;
    b_vld = 1'b1; b_typ = typ; b_addr = addr; b_tid = tid; b_wd = wd; b_be = be;
    @(negedge clk); chk({tag, "_rdy"}, b_rdy, 1'b1);
    @(posedge clk); #1; b_vld = 1'b0; e0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_rv && n < 20);
    chk({tag, "_seen"}, b_rv, 1'b1);
    chk({tag, "_lat"}, cyc - e0, exp_lat);
    chk({tag, "_type"}, b_rtyp, typ);
    chk({tag, "_tid"}, b_rtid, tid);
    chk({tag, "_data"}, b_rdata, exp_d);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", a_rdy, 1'b0);
    chk("reset_rvalid", a_rv, 1'b0);
    chk("reset_rtype", a_rtyp, 1'b0);
    chk("reset_rtid", a_rtid, 2'b0);
    chk("reset_rdata", a_rdata, 128'b0);
    chk("reset_busy", a_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon = 1'b1;

    // memory is not reset: preload the region the tests read
    for (int w = 0; w < 64; w++) send(1'b1, 64'(w * 8), 2'(w), {$urandom, $urandom}, 8'hFF);
    drain();

    // line refill spanning two words
    send(1'b1, 64'h80, 2'd0, 64'h1111_2222_3333_4444, 8'hFF);
    send(1'b1, 64'h88, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    drain();
    send(1'b0, 64'h88, 2'd1, 64'h0, 8'h00);
    drain();

    // partial store followed by a load of the same line
    send(1'b1, 64'h100, 2'd0, 64'h0, 8'hFF);
    send(1'b1, 64'h100, 2'd2, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F);
    send(1'b0, 64'h100, 2'd3, 64'h0, 8'h00);
    drain();

    // five back-to-back loads overrun the 4-entry queue
    for (int i = 0; i < 5; i++) send(1'b0, 64'(($urandom_range(0, 63)) * 8), 2'(i), 64'h0, 8'h00);
    drain();

    // address beyond memory wraps to the same line as 0x8
    send(1'b0, 64'h2008, 2'd1, 64'h0, 8'h00);
    send(1'b0, 64'h8, 2'd2, 64'h0, 8'h00);
    drain();

    for (int k = 0; k < 300; k++) begin
      ra = {$urandom, $urandom};
      ra[12:3] = 10'($urandom_range(0, 63));
      send(1'($urandom_range(0, 1)), ra, 2'($urandom), {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(0, 8));
    end
    drain();

    // reset while the head load sits in WAIT with two more queued
    send(1'b0, 64'h10, 2'd1, 64'h0, 8'h00);
    begin
      int p1;
      p1 = last_p;
      send(1'b0, 64'h20, 2'd2, 64'h0, 8'h00);
      send(1'b0, 64'h30, 2'd3, 64'h0, 8'h00);
      a_vld = 1'b0;
      while (cyc < p1 + 3) begin @(posedge clk); #1; end
    end
    do_reset();
    @(negedge clk);
    chk("post_rst_busy", a_busy, 1'b0);
    chk("post_rst_ready", a_rdy, 1'b1);
    @(posedge clk); #1;
    gap(12);
    send(1'b0, 64'h88, 2'd0, 64'h0, 8'h00);
    drain();

    // zero extra latency instance
    b_txn("b_pre0", 1'b1, 64'h0, 2'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 128'h0, 2);
    b_txn("b_pre1", 1'b1, 64'h8, 2'd1, 64'h5555_6666_7777_8888, 8'hFF, 128'h0, 2);
    b_txn("b_be0",  1'b1, 64'h0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 128'h0, 2);
    b_txn("b_ld0",  1'b0, 64'h0, 2'd2, 64'h0, 8'h00, 128'h5555_6666_7777_8888_0123_4567_89AB_CDEF, 3);
    b_txn("b_bea5", 1'b1, 64'h8, 2'd0, 64'h1122_3344_5566_7788, 8'hA5, 128'h0, 2);
    b_txn("b_ld1",  1'b0, 64'hC, 2'd1, 64'h0, 8'h00, 128'h1155_3366_7766_8888_0123_4567_89AB_CDEF, 3);
    @(negedge clk);
    chk("b_idle_busy", b_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
